// File: rtl/slc3_mem_pkg.sv
// ----------------------------------------------------------------------------
// slc3_mem_pkg
// Shared types for the SLC-3 memory arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, CAPTURE, DONE)
//   requester_t : identifies which port owns the current access
//   LAT_CNT_W   : width of the read-latency countdown (covers latencies 1..7)
// ----------------------------------------------------------------------------
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } requester_t;

  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/slc3_latency_timer.sv
// ----------------------------------------------------------------------------
// slc3_latency_timer
// Read-latency countdown for the memory arbiter. A start pulse loads
// MEM_LATENCY-1; the count then decrements once per cycle and stops at 0.
// expired is high whenever the count is 0.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-low reset
//   start   in  load MEM_LATENCY-1 on this edge
//   expired out count has reached 0
// ----------------------------------------------------------------------------
module slc3_latency_timer
  import slc3_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic expired
);

  localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(MEM_LATENCY - 1);

  logic [LAT_CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= LOAD_VAL;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - LAT_CNT_W'(1);
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/slc3_mem_arbiter.sv
// ----------------------------------------------------------------------------
// slc3_mem_arbiter
// Shares the single-port SLC-3 memory between the CPU (MAR/MDR path) and the
// program loader / debug port. One access at a time: the winner's request is
// latched in IDLE, issued as a single mem_en_o strobe, read data is captured
// MEM_LATENCY cycles after the strobe, and a one-cycle ready pulse completes it.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : contested grants alternate against last_winner
//   undefined : CPU priority with a starvation guard (loader wins after
//               MAX_CPU_RUN consecutive CPU grants while it waits)
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU request, held until cpu_ready_o
//   cpu_rdata_o, cpu_ready_o      CPU read data (held) and completion pulse
//   ldr_req_i/we_i/addr_i/wdata_i loader request, same semantics
//   ldr_rdata_o, ldr_ready_o      loader read data (held) and completion pulse
//   mem_en_o, mem_we_o            memory strobe (one cycle/access), write enable
//   mem_addr_o, mem_wdata_o       latched address and write data
//   mem_rdata_i                   memory read data, valid MEM_LATENCY after strobe
//   busy_o                        high in any state other than IDLE
// ----------------------------------------------------------------------------
module slc3_mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_CPU_RUN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ready_o,
  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic [DATA_W-1:0] ldr_rdata_o,
  output logic              ldr_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  arb_state_t  state_reg, state_next;
  requester_t  win_reg;
  logic        we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic [DATA_W-1:0] ldr_rdata_reg;

  logic        any_req;
  logic        grant;
  requester_t  grant_who;
  logic        timer_start;
  logic        lat_expired;

  assign any_req = cpu_req_i | ldr_req_i;
  assign grant   = (state_reg == IDLE) && any_req;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  requester_t last_winner_reg;

  // Contested: give it to whoever did not win last. Uncontested: the requester.
  assign grant_who = (ldr_req_i && (!cpu_req_i || last_winner_reg == REQ_CPU))
                     ? REQ_LDR : REQ_CPU;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_winner_reg <= REQ_LDR;   // so the CPU takes the first contested grant
    end else if (grant) begin
      last_winner_reg <= grant_who;
    end
  end
`else
  localparam int RUN_W = $clog2(MAX_CPU_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

  logic [RUN_W-1:0] run_cnt_reg;

  // CPU has priority unless the loader has waited through RUN_MAX CPU grants.
  assign grant_who = (ldr_req_i && (!cpu_req_i || run_cnt_reg == RUN_MAX))
                     ? REQ_LDR : REQ_CPU;

  // Counts CPU grants only while the loader is waiting; any gap in ldr_req_i
  // or a loader grant restarts the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_cnt_reg <= '0;
    end else if (!ldr_req_i) begin
      run_cnt_reg <= '0;
    end else if (grant) begin
      if (grant_who == REQ_LDR) begin
        run_cnt_reg <= '0;
      end else if (run_cnt_reg != RUN_MAX) begin
        run_cnt_reg <= run_cnt_reg + RUN_W'(1);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read-latency timer: loaded as the access leaves IDLE so that it reads 0
  // exactly MEM_LATENCY-1 cycles after the strobe cycle.
  // --------------------------------------------------------------------------
  slc3_latency_timer #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_latency_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .expired (lat_expired)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_start = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next  = ISSUE;
          timer_start = 1'b1;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next = DONE;
        end else if (lat_expired) begin
          state_next = CAPTURE;       // MEM_LATENCY = 1: no wait cycles
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_expired) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch: requester inputs are ignored after this until ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_reg   <= REQ_CPU;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (grant) begin
      win_reg <= grant_who;
      if (grant_who == REQ_LDR) begin
        we_reg    <= ldr_we_i;
        addr_reg  <= ldr_addr_i;
        wdata_reg <= ldr_wdata_i;
      end else begin
        we_reg    <= cpu_we_i;
        addr_reg  <= cpu_addr_i;
        wdata_reg <= cpu_wdata_i;
      end
    end
  end

  // Per-port read data, held until that port's next read completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rdata_reg <= '0;
      ldr_rdata_reg <= '0;
    end else if (state_reg == CAPTURE) begin
      if (win_reg == REQ_LDR) begin
        ldr_rdata_reg <= mem_rdata_i;
      end else begin
        cpu_rdata_reg <= mem_rdata_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_en_o    = (state_reg == ISSUE);
  assign mem_we_o    = (state_reg == ISSUE) && we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign cpu_ready_o = (state_reg == DONE) && (win_reg == REQ_CPU);
  assign ldr_ready_o = (state_reg == DONE) && (win_reg == REQ_LDR);
  assign cpu_rdata_o = cpu_rdata_reg;
  assign ldr_rdata_o = ldr_rdata_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_slc3_mem_arbiter
// Directed bench for slc3_mem_arbiter with a behavioural two-cycle memory.
// Expected values are hand-derived; ARB_ROUND_ROBIN_EN selects the expected
// grant pattern of the contention scenario.
// ----------------------------------------------------------------------------
module tb_slc3_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req_i, cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_ready_o;
  logic          ldr_req_i, ldr_we_i;
  logic [AW-1:0] ldr_addr_i;
  logic [DW-1:0] ldr_wdata_i;
  logic [DW-1:0] ldr_rdata_o;
  logic          ldr_ready_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slc3_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_LATENCY (LAT),
    .MAX_CPU_RUN (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_ready_o (cpu_ready_o),
    .ldr_req_i   (ldr_req_i),
    .ldr_we_i    (ldr_we_i),
    .ldr_addr_i  (ldr_addr_i),
    .ldr_wdata_i (ldr_wdata_i),
    .ldr_rdata_o (ldr_rdata_o),
    .ldr_ready_o (ldr_ready_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  // Memory model: read data appears exactly two cycles after a read strobe,
  // DEAD otherwise, so a capture on the wrong cycle is visible.
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] rd_pipe;

  always @(posedge clk) begin
    if (!reset) begin
      mem[16'h0010] <= 16'h1234;
      mem[16'h0020] <= 16'hBEEF;
    end else if (mem_en_o && mem_we_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
    end
    rd_pipe     <= (mem_en_o && !mem_we_o) ? mem[mem_addr_o] : 16'hDEAD;
    mem_rdata_i <= rd_pipe;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
    ldr_req_i = 0; ldr_we_i = 0; ldr_addr_i = '0; ldr_wdata_i = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (3) step();
    checks++;
    if ({cpu_rdata_o, cpu_ready_o, ldr_rdata_o, ldr_ready_o, mem_en_o, mem_we_o,
         mem_addr_o, mem_wdata_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cpu_rdata=%h cpu_rdy=%b ldr_rdata=%h ldr_rdy=%b en=%b we=%b addr=%h wdata=%h busy=%b, required all 0",
               cpu_rdata_o, cpu_ready_o, ldr_rdata_o, ldr_ready_o, mem_en_o, mem_we_o,
               mem_addr_o, mem_wdata_o, busy_o);
    end
    reset = 1'b1;
    step();
    $display("reset: outputs=%h busy=%b", {mem_en_o, cpu_ready_o, ldr_ready_o}, busy_o);
  endtask

  // Scenario 1: CPU read x0010 -> x1234, strobe at +1, ready at +4.
  task automatic test_cpu_read();
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 16'h0010;
    step();
    checks++;
    if ({mem_en_o, mem_we_o, mem_addr_o, busy_o} !== {1'b1, 1'b0, 16'h0010, 1'b1}) begin
      errors++;
      $display("FAIL cpu_read_issue: en=%b we=%b addr=%h busy=%b, required en=1 we=0 addr=0010 busy=1",
               mem_en_o, mem_we_o, mem_addr_o, busy_o);
    end
    step();
    checks++;
    if ({mem_en_o, cpu_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL cpu_read_wait: en=%b ready=%b, required 0 0", mem_en_o, cpu_ready_o);
    end
    step();
    checks++;
    if (cpu_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_early_ready: ready=%b at +3, required 0", cpu_ready_o);
    end
    step();
    checks++;
    if ({cpu_ready_o, ldr_ready_o, cpu_rdata_o} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL cpu_read_done: cpu_rdy=%b ldr_rdy=%b rdata=%h, required 1 0 1234",
               cpu_ready_o, ldr_ready_o, cpu_rdata_o);
    end
    $display("cpu_read x0010: ready=%b rdata=%h", cpu_ready_o, cpu_rdata_o);
    cpu_req_i = 0;
    step();
    checks++;
    if ({cpu_ready_o, busy_o, cpu_rdata_o} !== {1'b0, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL cpu_read_after: ready=%b busy=%b rdata=%h, required 0 0 1234 (held)",
               cpu_ready_o, busy_o, cpu_rdata_o);
    end
  endtask

  // Scenario 2: loader write x3000 <= x00A3, then read it back.
  task automatic test_ldr_write();
    int got;
    ldr_req_i = 1; ldr_we_i = 1; ldr_addr_i = 16'h3000; ldr_wdata_i = 16'h00A3;
    step();
    checks++;
    if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 16'h3000, 16'h00A3}) begin
      errors++;
      $display("FAIL ldr_write_issue: en=%b we=%b addr=%h wdata=%h, required 1 1 3000 00A3",
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    step();
    checks++;
    if ({mem_en_o, ldr_ready_o, cpu_ready_o} !== 3'b010) begin
      errors++;
      $display("FAIL ldr_write_done: en=%b ldr_rdy=%b cpu_rdy=%b, required 0 1 0",
               mem_en_o, ldr_ready_o, cpu_ready_o);
    end
    $display("ldr_write x3000<=00A3: ready=%b", ldr_ready_o);
    ldr_req_i = 0;
    step();
    checks++;
    if (mem[16'h3000] !== 16'h00A3) begin
      errors++;
      $display("FAIL ldr_write_mem: mem[3000]=%h, required 00A3", mem[16'h3000]);
    end
    // read back
    ldr_req_i = 1; ldr_we_i = 0;
    got = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (ldr_ready_o) begin got = c; break; end
    end
    checks++;
    if (got !== LAT + 2 || ldr_rdata_o !== 16'h00A3 || cpu_rdata_o !== 16'h1234) begin
      errors++;
      $display("FAIL ldr_readback: latency=%0d ldr_rdata=%h cpu_rdata=%h, required %0d 00A3 1234",
               got, ldr_rdata_o, cpu_rdata_o, LAT + 2);
    end
    $display("ldr_read x3000: latency=%0d rdata=%h", got, ldr_rdata_o);
    ldr_req_i = 0;
    step();
  endtask

  // Scenario 6: address change after the latch does not affect the access.
  task automatic test_addr_change();
    int got;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 16'h0010;
    got = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 2) begin cpu_addr_i = 16'h0020; cpu_we_i = 1; end
      if (cpu_ready_o) begin got = c; break; end
    end
    checks++;
    if (got !== LAT + 2 || cpu_rdata_o !== 16'h1234) begin
      errors++;
      $display("FAIL addr_change: latency=%0d rdata=%h, required %0d 1234", got, cpu_rdata_o, LAT + 2);
    end
    $display("addr_change during WAIT: latency=%0d rdata=%h", got, cpu_rdata_o);
    idle_inputs();
    step();
  endtask

  // Scenario 5: reset during WAIT aborts the read; a later read completes.
  task automatic test_reset_mid();
    int got;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 16'h0020;
    step();   // ISSUE
    step();   // WAIT
    reset = 1'b0;
    step();
    checks++;
    if ({cpu_rdata_o, cpu_ready_o, ldr_rdata_o, ldr_ready_o, mem_en_o, mem_we_o,
         mem_addr_o, mem_wdata_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: cpu_rdata=%h cpu_rdy=%b ldr_rdata=%h en=%b addr=%h busy=%b, required all 0",
               cpu_rdata_o, cpu_ready_o, ldr_rdata_o, mem_en_o, mem_addr_o, busy_o);
    end
    reset = 1'b1;
    cpu_req_i = 0;
    got = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (cpu_ready_o) got++;
    end
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_ready: ready pulses=%0d, required 0", got);
    end
    cpu_req_i = 1;
    got = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (cpu_ready_o) begin got = c; break; end
    end
    checks++;
    if (got !== LAT + 2 || cpu_rdata_o !== 16'hBEEF) begin
      errors++;
      $display("FAIL reset_mid_recover: latency=%0d rdata=%h, required %0d BEEF", got, cpu_rdata_o, LAT + 2);
    end
    $display("reset_mid then read x0020: latency=%0d rdata=%h", got, cpu_rdata_o);
    idle_inputs();
    step();
  endtask

  // Scenario 4: simultaneous requests right after reset -> CPU first.
  task automatic test_both_same_cycle();
    int got;
    reset = 1'b0; idle_inputs(); step(); reset = 1'b1;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 16'h0010;
    ldr_req_i = 1; ldr_we_i = 0; ldr_addr_i = 16'h3000;
    got = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (cpu_ready_o || ldr_ready_o) begin got = c; break; end
    end
    checks++;
    if (got == 0 || {cpu_ready_o, ldr_ready_o} !== 2'b10 || cpu_rdata_o !== 16'h1234) begin
      errors++;
      $display("FAIL both_first_grant: cyc=%0d cpu_rdy=%b ldr_rdy=%b cpu_rdata=%h, required CPU first with 1234",
               got, cpu_ready_o, ldr_ready_o, cpu_rdata_o);
    end
    $display("both_same_cycle first: cpu_rdy=%b ldr_rdy=%b", cpu_ready_o, ldr_ready_o);
    cpu_req_i = 0;
    got = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (ldr_ready_o) begin got = c; break; end
    end
    checks++;
    if (got == 0 || ldr_rdata_o !== 16'h00A3) begin
      errors++;
      $display("FAIL both_second_grant: cyc=%0d ldr_rdata=%h, required loader ready with 00A3",
               got, ldr_rdata_o);
    end
    $display("both_same_cycle second: ldr_rdata=%h", ldr_rdata_o);
    idle_inputs();
    step();
  endtask

  // Scenario 3 and back-to-back: both held high continuously with writes.
  task automatic test_back_to_back();
    int grants;
    int cyc;
    logic exp_ldr;
    reset = 1'b0; idle_inputs(); step(); reset = 1'b1;
    cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 16'h0100; cpu_wdata_i = 16'h1111;
    ldr_req_i = 1; ldr_we_i = 1; ldr_addr_i = 16'h0200; ldr_wdata_i = 16'h2222;
    grants = 0;
    cyc = 0;
    while (grants < 18 && cyc < 100) begin
      step();
      cyc++;
      if (cpu_ready_o || ldr_ready_o) begin
        grants++;
`ifdef ARB_ROUND_ROBIN_EN
        exp_ldr = (grants % 2 == 0);
`else
        exp_ldr = (grants % 9 == 0);
`endif
        checks++;
        if ({cpu_ready_o, ldr_ready_o} !== {~exp_ldr, exp_ldr}) begin
          errors++;
          $display("FAIL contention_grant%0d: cpu_rdy=%b ldr_rdy=%b, required cpu=%b ldr=%b",
                   grants, cpu_ready_o, ldr_ready_o, ~exp_ldr, exp_ldr);
        end
        $display("contention grant %0d: %s", grants, ldr_ready_o ? "LDR" : "CPU");
        step();
        cyc++;
        if (grants <= 3) begin
          checks++;
          if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle%0d: busy=%b after ready, required 0", grants, busy_o);
          end
        end
      end
    end
    checks++;
    if (grants !== 18) begin
      errors++;
      $display("FAIL contention_timeout: grants=%0d in %0d cycles, required 18", grants, cyc);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_addr_change();
    test_reset_mid();
    test_both_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
